// File: rtl/sega_joy_pkg.sv
// Shared types and field indices for the Sega/Atari DB9 joystick reader.
package sega_joy_pkg;

  localparam int PHASES = 8;

  typedef enum logic [2:0] {
    PH_0, PH_1, PH_2, PH_3, PH_4, PH_5, PH_6, PH_7
  } phase_t;

  // Raw pad pin positions inside one port's 6-bit joy_i slice.
  localparam int JI_UP    = 0;
  localparam int JI_DOWN  = 1;
  localparam int JI_LEFT  = 2;
  localparam int JI_RIGHT = 3;
  localparam int JI_P6    = 4;
  localparam int JI_P9    = 5;

  // Decoded button positions inside one port's 12-bit joy_o slice.
  localparam int JO_U = 0;
  localparam int JO_D = 1;
  localparam int JO_L = 2;
  localparam int JO_R = 3;
  localparam int JO_B = 4;
  localparam int JO_C = 5;
  localparam int JO_A = 6;
  localparam int JO_S = 7;
  localparam int JO_Z = 8;
  localparam int JO_Y = 9;
  localparam int JO_X = 10;
  localparam int JO_M = 11;

  // Select level driven once the given phase is left: high after odd phases.
  function automatic logic sel_after(phase_t ph);
    return ph[0];
  endfunction

endpackage

// File: rtl/sega_joy_port.sv
// One DB9 port: input synchroniser, per-frame shadow capture and atomic commit.
// Six-button detection and MXYZ capture exist only when JOY_SIX_BUTTON_EN is defined.
module sega_joy_port
  import sega_joy_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        step,
  input  phase_t      phase,
  input  logic [5:0]  pins,
  output logic [11:0] joy,
  output logic        six_btn
);

  logic [5:0]  sync_a;
  logic [5:0]  sync_b;
  logic [5:0]  held;
  logic [11:0] shadow;
  logic        shadow_six;

  // Pad pins are active-low; everything downstream works in pressed = 1.
  assign held = ~sync_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: non-blocking assignments keep the two synchroniser stages as distinct flops.
      sync_a <= '1;
      sync_b <= '1;
    end else begin
      sync_a <= pins;
      sync_b <= sync_a;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow     <= '0;
      shadow_six <= 1'b0;
      joy        <= '0;
      six_btn    <= 1'b0;
    end else if (step) begin
      case (phase)
        PH_2: begin
          shadow[JO_R:JO_U] <= held[JI_RIGHT:JI_UP];
          shadow[JO_C:JO_B] <= held[JI_P9:JI_P6];
          shadow_six        <= 1'b0;
        end
        PH_3: begin
          // Left+right together is impossible on a real pad: it marks an MD pad.
          if (held[JI_RIGHT] && held[JI_LEFT]) begin
            shadow[JO_S:JO_A] <= held[JI_P9:JI_P6];
          end else begin
            shadow[JO_S:JO_A] <= 2'b00;
            shadow[JO_C:JO_B] <= held[JI_P9:JI_P6];
          end
        end
`ifdef JOY_SIX_BUTTON_EN
        PH_5: begin
          if (&held[JI_RIGHT:JI_UP]) shadow_six <= 1'b1;
        end
        PH_6: begin
          shadow[JO_M:JO_Z] <= shadow_six ? held[JI_RIGHT:JI_UP] : 4'b0000;
        end
`endif
        PH_7: begin
          joy     <= shadow;
          six_btn <= shadow_six;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sega_joy_reader.sv
// Multi-port DB9 joystick reader: shared select line, 8-phase scan frame, per-port decode.
// Define JOY_SIX_BUTTON_EN to enable six-button pad detection and MXYZ capture.
module sega_joy_reader
  import sega_joy_pkg::*;
#(
  parameter int PORTS    = 2,
  parameter int TICK_DIV = 1536
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [PORTS*6-1:0]    joy_i,
  output logic                  sel_o,
  output logic [PORTS*12-1:0]   joy_o,
  output logic [PORTS-1:0]      six_btn_o,
  output logic                  valid_o
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [TW-1:0] tick;
  phase_t        phase;
  logic          step;

  assign step = (tick == TW'(TICK_DIV - 1));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      tick    <= '0;
      phase   <= PH_0;
      sel_o   <= 1'b1;
      valid_o <= 1'b0;
    end else begin
      valid_o <= step && (phase == PH_7);
      if (step) begin
        tick  <= '0;
        phase <= phase_t'(3'(phase + 3'd1));
        sel_o <= sel_after(phase);
      end else begin
        tick <= tick + TW'(1);
      end
    end
  end

  for (genvar p = 0; p < PORTS; p++) begin : g_port
    sega_joy_port u_port (
      .clk     (clk_i),
      .reset   (reset_i),
      .step    (step),
      .phase   (phase),
      .pins    (joy_i[6*p +: 6]),
      .joy     (joy_o[12*p +: 12]),
      .six_btn (six_btn_o[p])
    );
  end

endmodule

// File: tb/tb_sega_joy_reader.sv
// Directed bench for sega_joy_reader with behavioural pad models and a commit scoreboard.
module tb_sega_joy_reader;

  localparam int PORTS    = 2;
  localparam int TICK_DIV = 4;
  localparam int FRAME    = 8 * TICK_DIV;

  typedef enum int {PAD_NONE, PAD_MD3, PAD_MD6, PAD_SMS} pad_t;
  typedef struct packed {
    logic m, x, y, z, s, a, c, b, r, l, d, u;
  } btn_t;
  typedef struct {
    logic [PORTS*12-1:0] joy;
    logic [PORTS-1:0]    six;
  } exp_t;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [PORTS*6-1:0]  joy_pins;
  logic                sel;
  logic [PORTS*12-1:0] joy;
  logic [PORTS-1:0]    six;
  logic                valid;

  pad_t pad_type [PORTS];
  btn_t pad_btn  [PORTS];
  int   low_cnt;
  exp_t sb [$];
  int   checks = 0;
  int   errors = 0;

`ifdef JOY_SIX_BUTTON_EN
  localparam logic [11:0] SIX_WORD = 12'h480;
  localparam logic [1:0]  SIX_FLAG = 2'b10;
`else
  localparam logic [11:0] SIX_WORD = 12'h080;
  localparam logic [1:0]  SIX_FLAG = 2'b00;
`endif

  sega_joy_reader #(.PORTS(PORTS), .TICK_DIV(TICK_DIV)) dut (
    .clk_i     (clk),
    .reset_i   (reset),
    .joy_i     (joy_pins),
    .sel_o     (sel),
    .joy_o     (joy),
    .six_btn_o (six),
    .valid_o   (valid)
  );

  always #5 clk = ~clk;

  // Six-button pads count select-low pulses; four per frame.
  always @(negedge sel or posedge reset) begin
    if (reset) low_cnt <= 0;
    else       low_cnt <= (low_cnt == 4) ? 1 : low_cnt + 1;
  end

  // Returns pressed-high {p9, p6, R, L, D, U}; the pins are its complement.
  function automatic logic [5:0] pad_pressed(pad_t t, btn_t b, logic s, int n);
    logic [5:0] hi;
    hi = '0;
    case (t)
      PAD_SMS: hi = {b.c, b.b, b.r, b.l, b.d, b.u};
      PAD_MD3: hi = s ? {b.c, b.b, b.r, b.l, b.d, b.u} : {b.s, b.a, 1'b1, 1'b1, b.d, b.u};
      PAD_MD6: begin
        if (!s && n == 3)      hi = {b.s, b.a, 4'b1111};
        else if (s && n == 3)  hi = {b.c, b.b, b.m, b.x, b.y, b.z};
        else if (!s && n == 4) hi = {b.s, b.a, 4'b0000};
        else hi = s ? {b.c, b.b, b.r, b.l, b.d, b.u} : {b.s, b.a, 1'b1, 1'b1, b.d, b.u};
      end
      default: hi = '0;
    endcase
    return hi;
  endfunction

  always_comb begin
    joy_pins = '1;
    for (int p = 0; p < PORTS; p++)
      joy_pins[6*p +: 6] = ~pad_pressed(pad_type[p], pad_btn[p], sel, low_cnt);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input logic [PORTS*12-1:0] j, input logic [PORTS-1:0] s);
    exp_t e;
    e.joy = j;
    e.six = s;
    sb.push_back(e);
  endtask

  task automatic compare_sb(input string tag);
    exp_t e;
    check({tag, "_sb_depth"}, sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_joy"}, joy, e.joy);
      check({tag, "_six"}, six, e.six);
    end
  endtask

  // Called on the negedge after a valid_o (or reset release), n already elapsed.
  task automatic next_frame(input string tag, input int start);
    int         n = start;
    bit         stable = 1'b1;
    logic [PORTS*12-1:0] prev = joy;
    do begin
      @(negedge clk);
      n++;
      if (!valid && joy !== prev) stable = 1'b0;
    end while (!valid && n < FRAME + 8);
    check({tag, "_valid"}, valid, 1);
    check({tag, "_period"}, n, FRAME);
    check({tag, "_stable"}, stable, 1);
    compare_sb(tag);
  endtask

  task automatic set_pad(input int p, input pad_t t, input btn_t b);
    pad_type[p] = t;
    pad_btn[p]  = b;
  endtask

  initial begin
    btn_t b0, b1;
    for (int p = 0; p < PORTS; p++) set_pad(p, PAD_NONE, '0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_sel", sel, 1);
    check("rst_joy", joy, 0);
    check("rst_six", six, 0);
    check("rst_valid", valid, 0);

    // Unplugged: sel toggles every step, first commit one frame after release.
    push_exp('0, '0);
    reset = 1'b0;
    for (int c = 1; c <= FRAME; c++) begin
      @(negedge clk);
      if (c % TICK_DIV == 0) check("sel_seq", sel, ((c / TICK_DIV) % 2 == 0) ? 1 : 0);
      check("valid_seq", valid, (c == FRAME) ? 1 : 0);
    end
    compare_sb("none");

    // 3-button MD on port 0 (A + Right), 6-button on port 1 (X + Start).
    b0 = '0; b0.a = 1'b1; b0.r = 1'b1;
    b1 = '0; b1.x = 1'b1; b1.s = 1'b1;
    set_pad(0, PAD_MD3, b0);
    set_pad(1, PAD_MD6, b1);
    push_exp({SIX_WORD, 12'h048}, SIX_FLAG);
    next_frame("md", 0);

    // Master System pad: button 1 + Up; port 1 unplugged.
    b0 = '0; b0.b = 1'b1; b0.u = 1'b1;
    set_pad(0, PAD_SMS, b0);
    set_pad(1, PAD_NONE, '0);
    push_exp({12'h000, 12'h011}, 2'b00);
    next_frame("sms", 0);

    // Change between the phase-2 and phase-3 samples: frame mixes old RLDU with new C/B.
    repeat (13) @(negedge clk);
    b0 = '0; b0.c = 1'b1; b0.d = 1'b1;
    set_pad(0, PAD_SMS, b0);
    push_exp({12'h000, 12'h021}, 2'b00);
    next_frame("mid", 13);
    push_exp({12'h000, 12'h022}, 2'b00);
    next_frame("mid2", 0);

    // Reset asserted during phase 4 clears outputs asynchronously and restarts the frame.
    b0 = '0; b0.a = 1'b1; b0.r = 1'b1;
    b1 = '0; b1.x = 1'b1; b1.s = 1'b1;
    set_pad(0, PAD_MD3, b0);
    set_pad(1, PAD_MD6, b1);
    push_exp({SIX_WORD, 12'h048}, SIX_FLAG);
    next_frame("pre_rst", 0);
    repeat (18) @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_sel", sel, 1);
    check("mid_rst_joy", joy, 0);
    check("mid_rst_six", six, 0);
    check("mid_rst_valid", valid, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    push_exp({SIX_WORD, 12'h048}, SIX_FLAG);
    next_frame("post_rst", 0);

    // Unplug both pads.
    set_pad(0, PAD_NONE, '0);
    set_pad(1, PAD_NONE, '0);
    push_exp('0, '0);
    next_frame("unplug", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
